picoblaze_io_hub: RTL and testbench

PICOBLAZE_IO_HUB -- requirements
Module: picoblaze_io_hub

---
 rtl/picoblaze_io_pkg.sv | 30 +++
 rtl/picoblaze_io_hub_if.sv | 22 ++
 rtl/picoblaze_irq_ctrl.sv | 84 ++++++++
 rtl/picoblaze_io_hub.sv | 103 ++++++++++
 tb/tb_picoblaze_io_hub.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/picoblaze_io_pkg.sv
// Shared constants and types for the PicoBlaze I/O hub.
// Holds the I/O-space address map, the "no interrupt" code, the
// interrupt FSM state type and the priority-encoder helper.
package picoblaze_io_pkg;

  localparam logic [7:0] ADDR_IN_BASE  = 8'h20;
  localparam logic [7:0] ADDR_IRQ_PEND = 8'h40;
  localparam logic [7:0] ADDR_IRQ_MASK = 8'h41;
  localparam logic [7:0] ADDR_IRQ_ID   = 8'h42;
  localparam logic [7:0] ADDR_EOI      = 8'h43;

  localparam logic [7:0] IRQ_NONE      = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_SERVICE
  } irq_state_e;

  // Index of the lowest set bit, or IRQ_NONE when no bit is set.
  function automatic logic [7:0] irq_prio_id(input logic [7:0] v);
    logic [7:0] id;
    id = IRQ_NONE;
    for (int unsigned i = 0; i < 8; i++) begin
      if (v[i] && (id == IRQ_NONE)) id = 8'(i);
    end
    return id;
  endfunction

endpackage

// File: rtl/picoblaze_io_hub_if.sv
// KCPSM6 port bus as seen between the processor and the I/O hub.
//   master : processor side (drives address, write data, strobes, ack)
//   slave  : hub side (drives read data and the interrupt request)
interface picoblaze_io_hub_if;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] in_port;
  logic       interrupt;
  logic       interrupt_ack;

  modport master (
    output port_id, out_port, write_strobe, read_strobe, interrupt_ack,
    input  in_port, interrupt
  );

  modport slave (
    input  port_id, out_port, write_strobe, read_strobe, interrupt_ack,
    output in_port, interrupt
  );
endinterface

// File: rtl/picoblaze_irq_ctrl.sv
// Interrupt controller for the PicoBlaze I/O hub.
// Rising-edge detection on irq_src, pending (write-1-to-clear) and
// mask registers, lowest-index priority encoder and the IDLE/REQ/SERVICE
// request FSM.
//   clk, reset : clock, synchronous active-high reset
//   irq_src    : interrupt sources (edge-sensitive)
//   wr_pend    : W1C write to IRQ_PEND this cycle (data in wdata)
//   wr_mask    : write to IRQ_MASK this cycle (data in wdata)
//   wr_eoi     : write to EOI this cycle
//   wdata      : write data, low N_IRQ bits
//   ack        : interrupt acknowledge from the processor
//   pend, mask : current register contents
//   irq_id     : lowest enabled pending index, 0xFF when none
//   interrupt  : registered request, high exactly in REQ
module picoblaze_irq_ctrl
  import picoblaze_io_pkg::*;
#(
  parameter int unsigned N_IRQ = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_src,
  input  logic             wr_pend,
  input  logic             wr_mask,
  input  logic             wr_eoi,
  input  logic [N_IRQ-1:0] wdata,
  input  logic             ack,
  output logic [N_IRQ-1:0] pend,
  output logic [N_IRQ-1:0] mask,
  output logic [7:0]       irq_id,
  output logic             interrupt
);

  logic [N_IRQ-1:0] src_q, src_d;
  logic [N_IRQ-1:0] pend_q, pend_d;
  logic [N_IRQ-1:0] mask_q, mask_d;
  irq_state_e       state_q, state_d;
  logic             irq_q, irq_d;
  logic             active;

  always_comb begin
    src_d  = irq_src;
    mask_d = wr_mask ? wdata : mask_q;
    pend_d = pend_q;
    if (wr_pend) pend_d = pend_q & ~wdata;
    // New edges are OR-ed in after the clear so a set wins over W1C.
    pend_d = pend_d | (irq_src & ~src_q);

    active  = |(pend_q & mask_q);
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (active) state_d = ST_REQ;
      ST_REQ: begin
        if (ack)          state_d = ST_SERVICE;
        else if (!active) state_d = ST_IDLE;
      end
      ST_SERVICE: if (wr_eoi || wr_pend) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    irq_d = (state_d == ST_REQ);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q   <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      state_q <= ST_IDLE;
      irq_q   <= 1'b0;
    end else begin
      src_q   <= src_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      state_q <= state_d;
      irq_q   <= irq_d;
    end
  end

  assign pend      = pend_q;
  assign mask      = mask_q;
  assign irq_id    = irq_prio_id(8'(pend_q & mask_q));
  assign interrupt = irq_q;

endmodule

// File: rtl/picoblaze_io_hub.sv
// KCPSM6 I/O hub: output registers, input ports, interrupt controller
// and a 128-byte RAM window, all on the processor's port bus.
//   clk, reset : clock, synchronous active-high reset
//   bus        : KCPSM6 port bus (slave side)
//   out_data   : output registers, reg k in bits [8k+7:8k]
//   in_data    : input ports, port k in bits [8k+7:8k]
//   irq_src    : interrupt sources
//   ram_*      : combinational RAM window, selected by port_id[7]
module picoblaze_io_hub
  import picoblaze_io_pkg::*;
#(
  parameter int unsigned N_OUT = 4,
  parameter int unsigned N_IN  = 4,
  parameter int unsigned N_IRQ = 4
) (
  input  logic               clk,
  input  logic               reset,
  picoblaze_io_hub_if.slave  bus,
  output logic [8*N_OUT-1:0] out_data,
  input  logic [8*N_IN-1:0]  in_data,
  input  logic [N_IRQ-1:0]   irq_src,
  output logic               ram_sel,
  output logic [6:0]         ram_addr,
  output logic               ram_we,
  output logic [7:0]         ram_wdata,
  input  logic [7:0]         ram_rdata
);

  logic             io_wr;
  logic             wr_pend, wr_mask, wr_eoi;
  logic [N_IRQ-1:0] pend, mask;
  logic [7:0]       irq_id;
  logic [7:0]       out_q [N_OUT];
  logic [7:0]       out_d [N_OUT];
  logic [7:0]       in_port_q, in_port_d;

  // Reads are registered every cycle, so read_strobe carries no information.
  logic unused_read_strobe;
  assign unused_read_strobe = bus.read_strobe;

  assign ram_sel   = bus.port_id[7];
  assign ram_addr  = bus.port_id[6:0];
  assign ram_wdata = bus.out_port;
  assign ram_we    = bus.write_strobe & bus.port_id[7];

  assign io_wr   = bus.write_strobe & ~bus.port_id[7];
  assign wr_pend = io_wr && (bus.port_id == ADDR_IRQ_PEND);
  assign wr_mask = io_wr && (bus.port_id == ADDR_IRQ_MASK);
  assign wr_eoi  = io_wr && (bus.port_id == ADDR_EOI);

  picoblaze_irq_ctrl #(.N_IRQ(N_IRQ)) u_irq (
    .clk       (clk),
    .reset     (reset),
    .irq_src   (irq_src),
    .wr_pend   (wr_pend),
    .wr_mask   (wr_mask),
    .wr_eoi    (wr_eoi),
    .wdata     (bus.out_port[N_IRQ-1:0]),
    .ack       (bus.interrupt_ack),
    .pend      (pend),
    .mask      (mask),
    .irq_id    (irq_id),
    .interrupt (bus.interrupt)
  );

  always_comb begin
    for (int unsigned k = 0; k < N_OUT; k++) begin
      out_d[k] = out_q[k];
      if (io_wr && (bus.port_id == 8'(k))) out_d[k] = bus.out_port;
      out_data[8*k +: 8] = out_q[k];
    end
  end

  always_comb begin
    in_port_d = '0;
    if (bus.port_id[7]) begin
      in_port_d = ram_rdata;
    end else begin
      for (int unsigned k = 0; k < N_OUT; k++) begin
        if (bus.port_id == 8'(k)) in_port_d = out_q[k];
      end
      for (int unsigned k = 0; k < N_IN; k++) begin
        if (bus.port_id == ADDR_IN_BASE + 8'(k)) in_port_d = in_data[8*k +: 8];
      end
      if (bus.port_id == ADDR_IRQ_PEND) in_port_d = 8'(pend);
      if (bus.port_id == ADDR_IRQ_MASK) in_port_d = 8'(mask);
      if (bus.port_id == ADDR_IRQ_ID)   in_port_d = irq_id;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < N_OUT; k++) out_q[k] <= '0;
      in_port_q <= '0;
    end else begin
      for (int unsigned k = 0; k < N_OUT; k++) out_q[k] <= out_d[k];
      in_port_q <= in_port_d;
    end
  end

  assign bus.in_port = in_port_q;

endmodule

// File: tb/tb_picoblaze_io_hub.sv
module tb_picoblaze_io_hub;

  localparam int unsigned N_OUT = 4;
  localparam int unsigned N_IN  = 4;
  localparam int unsigned N_IRQ = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic [8*N_OUT-1:0] out_data;
  logic [8*N_IN-1:0]  in_data;
  logic [N_IRQ-1:0]   irq_src;
  logic               ram_sel;
  logic [6:0]         ram_addr;
  logic               ram_we;
  logic [7:0]         ram_wdata;
  logic [7:0]         ram_rdata;

  picoblaze_io_hub_if bus ();

  picoblaze_io_hub #(.N_OUT(N_OUT), .N_IN(N_IN), .N_IRQ(N_IRQ)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .out_data  (out_data),
    .in_data   (in_data),
    .irq_src   (irq_src),
    .ram_sel   (ram_sel),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } rd_exp_t;

  rd_exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    bus.port_id      = addr;
    bus.out_port     = data;
    bus.write_strobe = 1'b1;
    tick();
    bus.write_strobe = 1'b0;
  endtask

  // Expected read data is queued as the address is driven and retired
  // once the registered in_port has had its cycle to update.
  task automatic rd(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    rd_exp_t e;
    e.tag = tag;
    e.exp = exp;
    bus.port_id     = addr;
    bus.read_strobe = 1'b1;
    sb.push_back(e);
    tick();
    bus.read_strobe = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, 32'(bus.in_port), 32'(e.exp));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [31:0] out_exp;

  initial begin
    reset             = 1'b1;
    bus.port_id       = '0;
    bus.out_port      = '0;
    bus.write_strobe  = 1'b0;
    bus.read_strobe   = 1'b0;
    bus.interrupt_ack = 1'b0;
    in_data           = '0;
    irq_src           = '0;
    ram_rdata         = '0;
    out_exp           = '0;

    tick();
    tick();
    check("rst_in_port", 32'(bus.in_port), 32'h0);
    check("rst_irq", 32'(bus.interrupt), 32'h0);
    check("rst_out_data", out_data, 32'h0);

    // RAM window stays combinational while reset is held
    bus.port_id      = 8'h9A;
    bus.out_port     = 8'h3C;
    bus.write_strobe = 1'b1;
    #1;
    check("rst_ram_sel", 32'(ram_sel), 32'h1);
    check("rst_ram_addr", 32'(ram_addr), 32'h1A);
    check("rst_ram_we", 32'(ram_we), 32'h1);
    check("rst_ram_wdata", 32'(ram_wdata), 32'h3C);
    bus.write_strobe = 1'b0;
    reset = 1'b0;
    tick();

    // Output registers
    wr(8'h02, 8'hA5);
    out_exp[23:16] = 8'hA5;
    check("out_wr02", out_data, out_exp);
    rd("rd02", 8'h02, 8'hA5);

    // Input ports, unmapped and RAM reads
    in_data = 32'h0000_3C00;
    rd("rd21", 8'h21, 8'h3C);
    rd("rd30", 8'h30, 8'h00);
    ram_rdata   = 8'h77;
    bus.port_id = 8'h85;
    #1;
    check("ram_addr85", 32'(ram_addr), 32'h05);
    check("ram_sel85", 32'(ram_sel), 32'h1);
    check("ram_we_idle", 32'(ram_we), 32'h0);
    rd("rd85", 8'h85, 8'h77);

    bus.port_id      = 8'h85;
    bus.out_port     = 8'h5A;
    bus.write_strobe = 1'b1;
    #1;
    check("ram_we_wr", 32'(ram_we), 32'h1);
    check("ram_wdata", 32'(ram_wdata), 32'h5A);
    tick();
    bus.write_strobe = 1'b0;
    #1;
    check("ram_we_after", 32'(ram_we), 32'h0);
    check("out_ram_wr", out_data, out_exp);

    wr(8'h10, 8'hFF);
    wr(8'h04, 8'hFF);
    check("out_unmapped", out_data, out_exp);
    wr(8'h00, 8'h11);
    wr(8'h03, 8'h33);
    out_exp[7:0]   = 8'h11;
    out_exp[31:24] = 8'h33;
    check("out_wr_all", out_data, out_exp);
    rd("rd00", 8'h00, 8'h11);

    // Interrupts
    wr(8'h41, 8'h06);
    rd("rd_mask", 8'h41, 8'h06);
    bus.interrupt_ack = 1'b1;
    tick();
    bus.interrupt_ack = 1'b0;
    check("ack_idle", 32'(bus.interrupt), 32'h0);

    irq_src = 4'b0110;
    tick();
    check("irq_lat1", 32'(bus.interrupt), 32'h0);
    tick();
    check("irq_lat2", 32'(bus.interrupt), 32'h1);
    irq_src = 4'b0000;
    rd("rd_pend06", 8'h40, 8'h06);
    rd("rd_id1", 8'h42, 8'h01);
    wr(8'h43, 8'h00);
    check("eoi_in_req", 32'(bus.interrupt), 32'h1);
    bus.interrupt_ack = 1'b1;
    tick();
    bus.interrupt_ack = 1'b0;
    check("ack_req", 32'(bus.interrupt), 32'h0);
    wr(8'h40, 8'h02);
    check("w1c_svc", 32'(bus.interrupt), 32'h0);
    tick();
    check("reenter_req", 32'(bus.interrupt), 32'h1);
    rd("rd_id2", 8'h42, 8'h02);
    bus.interrupt_ack = 1'b1;
    tick();
    bus.interrupt_ack = 1'b0;
    wr(8'h43, 8'h00);
    check("eoi_svc", 32'(bus.interrupt), 32'h0);
    tick();
    check("eoi_reenter", 32'(bus.interrupt), 32'h1);
    wr(8'h40, 8'h04);
    check("w1c_in_req", 32'(bus.interrupt), 32'h1);
    tick();
    check("req_drop", 32'(bus.interrupt), 32'h0);
    rd("rd_pend0", 8'h40, 8'h00);
    rd("rd_id_none", 8'h42, 8'hFF);

    // Set wins over a same-cycle clear
    irq_src = 4'b0001;
    tick();
    irq_src = 4'b0000;
    tick();
    rd("rd_pend01", 8'h40, 8'h01);
    irq_src = 4'b0001;
    wr(8'h40, 8'h01);
    rd("set_beats_w1c", 8'h40, 8'h01);
    check("masked_no_irq", 32'(bus.interrupt), 32'h0);
    wr(8'h40, 8'h01);
    rd("w1c_clear", 8'h40, 8'h00);

    // Reset in SERVICE
    wr(8'h41, 8'h02);
    irq_src = 4'b0011;
    tick();
    tick();
    check("svc_prep_req", 32'(bus.interrupt), 32'h1);
    bus.interrupt_ack = 1'b1;
    tick();
    bus.interrupt_ack = 1'b0;
    check("svc_prep_ack", 32'(bus.interrupt), 32'h0);
    reset             = 1'b1;
    bus.port_id       = 8'h00;
    bus.out_port      = 8'hEE;
    bus.write_strobe  = 1'b1;
    bus.interrupt_ack = 1'b1;
    irq_src           = 4'b0111;
    tick();
    reset             = 1'b0;
    bus.write_strobe  = 1'b0;
    bus.interrupt_ack = 1'b0;
    irq_src           = 4'b0000;
    out_exp           = '0;
    check("rst2_out", out_data, out_exp);
    check("rst2_irq", 32'(bus.interrupt), 32'h0);
    check("rst2_in_port", 32'(bus.in_port), 32'h0);
    rd("rst2_pend", 8'h40, 8'h00);
    rd("rst2_mask", 8'h41, 8'h00);
    rd("rst2_out0", 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst2_quiet", 32'(bus.interrupt), 32'h0);
    end
    wr(8'h41, 8'h01);
    irq_src = 4'b0001;
    tick();
    tick();
    check("rst2_new_irq", 32'(bus.interrupt), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
